// File: rtl/mmio_devices_if.sv
// Memory-mapped register bus between a CPU-side master and mmio_devices.
//   addr/wdata : address and write data
//   wr_en      : write strobe (acts on the rising clock edge)
//   rd_en      : read strobe (qualifies read side effects only)
//   rdata      : combinational read data
//   rd_hit     : addr matches a mapped register
interface mmio_devices_if #(
  parameter int unsigned DBITS = 32
) ();
  logic [DBITS-1:0] addr;
  logic             wr_en;
  logic [DBITS-1:0] wdata;
  logic             rd_en;
  logic [DBITS-1:0] rdata;
  logic             rd_hit;

  modport master (output addr, output wr_en, output wdata, output rd_en,
                  input rdata, input rd_hit);
  modport slave  (input addr, input wr_en, input wdata, input rd_en,
                  output rdata, output rd_hit);
endinterface

// File: rtl/mmio_devices.sv
// Board I/O register block: HEX and LEDR output registers, synchronised keys,
// synchronised and debounced switches, each input channel with a
// READY/OVERRUN/IE control register and a shared registered interrupt.
// Ports:
//   clk, reset : clock (rising edge), asynchronous active-high reset
//   bus        : register bus (slave side), combinational read path
//   key_n      : raw active-low keys
//   sw         : raw switches
//   hex_out    : HEX register
//   ledr_out   : LEDR register
//   irq        : registered interrupt request
module mmio_devices #(
  parameter int unsigned     DBITS           = 32,
  parameter int unsigned     HEXBITS         = 24,
  parameter int unsigned     LEDRBITS        = 10,
  parameter int unsigned     KEYBITS         = 4,
  parameter int unsigned     SWBITS          = 10,
  parameter int unsigned     DEBOUNCE_CYCLES = 1000,
  parameter logic [DBITS-1:0] ADDRHEX        = DBITS'(32'hFFFFF000),
  parameter logic [DBITS-1:0] ADDRLEDR       = DBITS'(32'hFFFFF020),
  parameter logic [DBITS-1:0] ADDRKEY        = DBITS'(32'hFFFFF080),
  parameter logic [DBITS-1:0] ADDRKCTRL      = DBITS'(32'hFFFFF084),
  parameter logic [DBITS-1:0] ADDRSW         = DBITS'(32'hFFFFF090),
  parameter logic [DBITS-1:0] ADDRSCTRL      = DBITS'(32'hFFFFF094)
) (
  input  logic                clk,
  input  logic                reset,
  mmio_devices_if.slave       bus,
  input  logic [KEYBITS-1:0]  key_n,
  input  logic [SWBITS-1:0]   sw,
  output logic [HEXBITS-1:0]  hex_out,
  output logic [LEDRBITS-1:0] ledr_out,
  output logic                irq
);

  localparam int unsigned CNTW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HEXBITS-1:0] HEX_RST = HEXBITS'(24'hFEDEAD);

  logic [HEXBITS-1:0]  hex_q, hex_d;
  logic [LEDRBITS-1:0] ledr_q, ledr_d;
  logic [KEYBITS-1:0]  ksync_q, ksync_d, kdata_q, kdata_d;
  logic [SWBITS-1:0]   ssync1_q, ssync1_d, ssync2_q, ssync2_d;
  logic [SWBITS-1:0]   cand_q, cand_d, sdata_q, sdata_d;
  logic [CNTW-1:0]     cnt_q, cnt_d;
  logic                krdy_q, krdy_d, kov_q, kov_d, kie_q, kie_d;
  logic                srdy_q, srdy_d, sov_q, sov_d, sie_q, sie_d;
  logic                irq_q, irq_d;

  // Address decode over the full bus width
  logic hit_hex_c, hit_ledr_c, hit_key_c, hit_kctrl_c, hit_sw_c, hit_sctrl_c;
  assign hit_hex_c   = (bus.addr == ADDRHEX);
  assign hit_ledr_c  = (bus.addr == ADDRLEDR);
  assign hit_key_c   = (bus.addr == ADDRKEY);
  assign hit_kctrl_c = (bus.addr == ADDRKCTRL);
  assign hit_sw_c    = (bus.addr == ADDRSW);
  assign hit_sctrl_c = (bus.addr == ADDRSCTRL);

  logic wr_kctrl_c, wr_sctrl_c, clr_k_c, clr_s_c, k_chg_c, s_chg_c;
  assign wr_kctrl_c = bus.wr_en && hit_kctrl_c;
  assign wr_sctrl_c = bus.wr_en && hit_sctrl_c;
  assign clr_k_c    = bus.rd_en && hit_key_c;
  assign clr_s_c    = bus.rd_en && hit_sw_c;
  assign k_chg_c    = (ksync_q != kdata_q);
  assign s_chg_c    = (sdata_d != sdata_q);

  // Only the low bits of wdata reach any register
  logic unused_wdata;
  assign unused_wdata = &{1'b0, bus.wdata};

  // Combinational read mux
  always_comb begin
    bus.rdata  = '0;
    bus.rd_hit = 1'b1;
    if (hit_hex_c)        bus.rdata = DBITS'(hex_q);
    else if (hit_ledr_c)  bus.rdata = DBITS'(ledr_q);
    else if (hit_key_c)   bus.rdata = DBITS'(kdata_q);
    else if (hit_kctrl_c) bus.rdata = DBITS'({kie_q, 2'b00, kov_q, krdy_q});
    else if (hit_sw_c)    bus.rdata = DBITS'(sdata_q);
    else if (hit_sctrl_c) bus.rdata = DBITS'({sie_q, 2'b00, sov_q, srdy_q});
    else                  bus.rd_hit = 1'b0;
  end

  // Next-state logic
  always_comb begin
    hex_d    = hex_q;
    ledr_d   = ledr_q;
    ksync_d  = ~key_n;
    kdata_d  = ksync_q;
    ssync1_d = sw;
    ssync2_d = ssync1_q;
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    sdata_d  = sdata_q;
    krdy_d   = krdy_q;
    kov_d    = kov_q;
    kie_d    = kie_q;
    srdy_d   = srdy_q;
    sov_d    = sov_q;
    sie_d    = sie_q;
    irq_d    = (krdy_q & kie_q) | (srdy_q & sie_q);

    if (bus.wr_en && hit_hex_c)  hex_d  = bus.wdata[HEXBITS-1:0];
    if (bus.wr_en && hit_ledr_c) ledr_d = bus.wdata[LEDRBITS-1:0];

    // Debouncer: restart the window on any new synchronised value
    if (ssync2_q != cand_q) begin
      cand_d = ssync2_q;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNTW'(1);
    end
    if ((cnt_q == CNT_MAX) && (cand_q != sdata_q)) sdata_d = cand_q;

    // Key status: a change wins over a coinciding clearing read
    if (wr_kctrl_c) begin
      kie_d = bus.wdata[4];
      if (!bus.wdata[1]) kov_d = 1'b0;
    end
    if (k_chg_c) begin
      krdy_d = 1'b1;
      if (krdy_q && !clr_k_c) kov_d = 1'b1;
    end else if (clr_k_c) begin
      krdy_d = 1'b0;
    end

    // Switch status, same rules as keys
    if (wr_sctrl_c) begin
      sie_d = bus.wdata[4];
      if (!bus.wdata[1]) sov_d = 1'b0;
    end
    if (s_chg_c) begin
      srdy_d = 1'b1;
      if (srdy_q && !clr_s_c) sov_d = 1'b1;
    end else if (clr_s_c) begin
      srdy_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex_q    <= HEX_RST;
      ledr_q   <= '0;
      ksync_q  <= '0;
      kdata_q  <= '0;
      ssync1_q <= '0;
      ssync2_q <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      sdata_q  <= '0;
      krdy_q   <= 1'b0;
      kov_q    <= 1'b0;
      kie_q    <= 1'b0;
      srdy_q   <= 1'b0;
      sov_q    <= 1'b0;
      sie_q    <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      hex_q    <= hex_d;
      ledr_q   <= ledr_d;
      ksync_q  <= ksync_d;
      kdata_q  <= kdata_d;
      ssync1_q <= ssync1_d;
      ssync2_q <= ssync2_d;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      sdata_q  <= sdata_d;
      krdy_q   <= krdy_d;
      kov_q    <= kov_d;
      kie_q    <= kie_d;
      srdy_q   <= srdy_d;
      sov_q    <= sov_d;
      sie_q    <= sie_d;
      irq_q    <= irq_d;
    end
  end

  assign hex_out  = hex_q;
  assign ledr_out = ledr_q;
  assign irq      = irq_q;

endmodule
